// File: rtl/condicionador_navegacao.sv
// Menu-key conditioner: turns the raw right/left/enter keys into clean,
// mutually exclusive single-cycle pulses. Each key is synchronised,
// debounced and edge detected. The arrows also auto-repeat while held.
module condicionador_navegacao #(
  parameter int DEBOUNCE_TIME = 1_000_000,
  parameter int REPEAT_DELAY  = 25_000_000,
  parameter int REPEAT_PERIOD = 10_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       right_raw,
  input  logic       left_raw,
  input  logic       enter_raw,
  output logic       right_arrow_pressed,
  output logic       left_arrow_pressed,
  output logic       enter_pressed,
  output logic [2:0] db_estaveis
);

  localparam int DB_W = $clog2(DEBOUNCE_TIME) + 1;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_TIME - 1);

  // The hold counter is shared by both waiting phases, so size it for the longer one
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX) + 1;
  localparam logic [RP_W-1:0] DELAY_LAST  = RP_W'(REPEAT_DELAY - 1);
  localparam logic [RP_W-1:0] PERIOD_LAST = RP_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    SOLTO  = 2'd0,
    ESPERA = 2'd1,
    REPETE = 2'd2
  } estado_t;

  // Channel order everywhere: bit 0 = right, bit 1 = left, bit 2 = enter
  logic [2:0] w_raw;
  logic [2:0] w_stable;
  logic [2:0] w_press;
  logic [1:0] w_repeat;
  logic       w_both_held;
  logic       w_cand_right;
  logic       w_cand_left;
  logic       w_cand_enter;
  logic       r_right_pulse;
  logic       r_left_pulse;
  logic       r_enter_pulse;

  assign w_raw = {enter_raw, left_raw, right_raw};

  genvar gi;

  // Per-key synchroniser, debouncer and press detector
  generate
    for (gi = 0; gi < 3; gi++) begin : g_canal
      logic            r_sync1;
      logic            r_sync2;
      logic            r_stable;
      logic            r_stable_d;
      logic [DB_W-1:0] r_db_cnt;

      // Two-flop synchroniser for the asynchronous key input
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_sync1 <= 1'b0;
          r_sync2 <= 1'b0;
        end else begin
          r_sync1 <= w_raw[gi];
          r_sync2 <= r_sync1;
        end
      end

      // Stable level flips only after DEBOUNCE_TIME consecutive differing samples
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_stable <= 1'b0;
          r_db_cnt <= '0;
        end else if (r_sync2 == r_stable) begin
          r_db_cnt <= '0;
        end else if (r_db_cnt == DB_LAST) begin
          r_stable <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DB_W'(1);
        end
      end

      // Previous stable level; with it the key behaves as a two-state
      // released/held machine whose only output is the press event
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_stable_d <= 1'b0;
        end else begin
          r_stable_d <= r_stable;
        end
      end

      assign w_stable[gi] = r_stable;
      assign w_press[gi]  = r_stable & ~r_stable_d;
    end
  endgenerate

  // Holding both arrows freezes auto-repeat on both of them
  assign w_both_held = w_stable[0] & w_stable[1];

  // Auto-repeat machines, arrows only
  generate
    for (gi = 0; gi < 2; gi++) begin : g_repete
      estado_t         r_estado;
      logic [RP_W-1:0] r_hold;
      logic            w_limite;

      assign w_limite = (r_estado == ESPERA) ? (r_hold == DELAY_LAST)
                                             : (r_hold == PERIOD_LAST);

      // A repeat candidate exists only while the key is held alone and its timer expires
      assign w_repeat[gi] = REPEAT_EN && w_stable[gi] && !w_both_held &&
                            (r_estado != SOLTO) && w_limite;

      // Hold timer: first wait REPEAT_DELAY after the press, then every REPEAT_PERIOD
      always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
          r_estado <= SOLTO;
          r_hold   <= '0;
        end else if (!REPEAT_EN || !w_stable[gi] || w_both_held) begin
          r_estado <= SOLTO;
          r_hold   <= '0;
        end else if (w_press[gi]) begin
          r_estado <= ESPERA;
          r_hold   <= '0;
        end else begin
          case (r_estado)
            SOLTO: begin
              r_hold <= '0;
            end
            ESPERA: begin
              if (r_hold == DELAY_LAST) begin
                r_estado <= REPETE;
                r_hold   <= '0;
              end else begin
                r_hold <= r_hold + RP_W'(1);
              end
            end
            REPETE: begin
              if (r_hold == PERIOD_LAST) begin
                r_hold <= '0;
              end else begin
                r_hold <= r_hold + RP_W'(1);
              end
            end
            default: begin
              r_estado <= SOLTO;
              r_hold   <= '0;
            end
          endcase
        end
      end
    end
  endgenerate

  assign w_cand_right = w_press[0] | w_repeat[0];
  assign w_cand_left  = w_press[1] | w_repeat[1];
  assign w_cand_enter = w_press[2];

  // Arbitration: enter beats both arrows; simultaneous arrows cancel each other
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_right_pulse <= 1'b0;
      r_left_pulse  <= 1'b0;
      r_enter_pulse <= 1'b0;
    end else begin
      r_enter_pulse <= w_cand_enter;
      r_right_pulse <= w_cand_right & ~w_cand_left & ~w_cand_enter;
      r_left_pulse  <= w_cand_left & ~w_cand_right & ~w_cand_enter;
    end
  end

  assign right_arrow_pressed = r_right_pulse;
  assign left_arrow_pressed  = r_left_pulse;
  assign enter_pressed       = r_enter_pulse;
  assign db_estaveis         = w_stable;

endmodule

// File: tb/tb_condicionador_navegacao.sv
// Bench for condicionador_navegacao: a window/time-based reference model
// predicts every cycle's outputs into a queue; a monitor pops and compares.
// Directed scenarios additionally check absolute pulse times.
module tb_condicionador_navegacao;

  localparam int D    = 4;
  localparam int RD   = 20;
  localparam int RPER = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       right_raw = 1'b0;
  logic       left_raw = 1'b0;
  logic       enter_raw = 1'b0;
  logic       right_arrow_pressed;
  logic       left_arrow_pressed;
  logic       enter_pressed;
  logic [2:0] db_estaveis;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [5:0] exp_q[$];
  int r_times[$];
  int l_times[$];
  int e_times[$];

  condicionador_navegacao #(
    .DEBOUNCE_TIME(D),
    .REPEAT_DELAY(RD),
    .REPEAT_PERIOD(RPER),
    .REPEAT_EN(1'b1)
  ) dut (
    .clock(clock),
    .reset(reset),
    .right_raw(right_raw),
    .left_raw(left_raw),
    .enter_raw(enter_raw),
    .right_arrow_pressed(right_arrow_pressed),
    .left_arrow_pressed(left_arrow_pressed),
    .enter_pressed(enter_pressed),
    .db_estaveis(db_estaveis)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  // hist[c][0] = raw sampled at the previous edge, hist[c][1] = two edges ago, ...
  bit       m_hist [3][D+1];
  bit [2:0] m_st, m_st_prev, m_st_new, m_raw, m_press, m_cand;
  bit [1:0] m_rep;
  bit       m_act [2];
  int       m_p [2];
  bit       m_diff, m_both;
  int       m_d;

  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      if (!reset) begin
        for (int c = 0; c < 3; c++)
          for (int j = 0; j <= D; j++) m_hist[c][j] = 1'b0;
        m_st = '0;
        m_st_prev = '0;
        m_act[0] = 1'b0;
        m_act[1] = 1'b0;
        exp_q.push_back(6'd0);
      end else begin
        m_raw = {enter_raw, left_raw, right_raw};
        // Stable level flips when the last D synchronised samples all disagree with it
        for (int c = 0; c < 3; c++) begin
          m_diff = 1'b1;
          for (int i = 0; i < D; i++)
            if (m_hist[c][1+i] == m_st[c]) m_diff = 1'b0;
          m_st_new[c] = m_diff ? ~m_st[c] : m_st[c];
          for (int j = D; j > 0; j--) m_hist[c][j] = m_hist[c][j-1];
          m_hist[c][0] = m_raw[c];
        end
        m_press = m_st & ~m_st_prev;
        m_both  = m_st[0] & m_st[1];
        // Repeats fall at press + RD + n*RPER while held alone
        for (int a = 0; a < 2; a++) begin
          m_rep[a] = 1'b0;
          if (!m_st[a] || m_both) begin
            m_act[a] = 1'b0;
          end else if (m_press[a]) begin
            m_act[a] = 1'b1;
            m_p[a] = cyc;
          end else if (m_act[a]) begin
            m_d = cyc - m_p[a];
            if (m_d == RD || (m_d > RD && (m_d - RD) % RPER == 0)) m_rep[a] = 1'b1;
          end
        end
        m_cand = m_press | {1'b0, m_rep};
        exp_q.push_back({m_st_new,
                         m_cand[2],
                         m_cand[1] & ~m_cand[0] & ~m_cand[2],
                         m_cand[0] & ~m_cand[1] & ~m_cand[2]});
        m_st_prev = m_st;
        m_st = m_st_new;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic [5:0] mon_exp, mon_got;
  initial begin
    forever begin
      @(negedge clock);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty cycle %0d: no prediction available", cyc);
      end else begin
        mon_exp = exp_q.pop_front();
        if (!reset) mon_exp = 6'd0;
        mon_got = {db_estaveis, enter_pressed, left_arrow_pressed, right_arrow_pressed};
        if (mon_got !== mon_exp) begin
          errors++;
          $display("FAIL outputs cycle %0d: got db=%b e/l/r=%b expected db=%b e/l/r=%b",
                   cyc, mon_got[5:3], mon_got[2:0], mon_exp[5:3], mon_exp[2:0]);
        end
      end
      if (right_arrow_pressed) r_times.push_back(cyc);
      if (left_arrow_pressed)  l_times.push_back(cyc);
      if (enter_pressed)       e_times.push_back(cyc);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clear_times();
    r_times.delete();
    l_times.delete();
    e_times.delete();
  endtask

  task automatic chk_times(input string nm, input int got[$], input int want[$]);
    checks++;
    if (got.size() != want.size()) begin
      errors++;
      $display("FAIL %s pulse count got %0d expected %0d", nm, got.size(), want.size());
    end else begin
      for (int i = 0; i < want.size(); i++) begin
        checks++;
        if (got[i] != want[i]) begin
          errors++;
          $display("FAIL %s pulse[%0d] at cycle got %0d expected %0d", nm, i, got[i], want[i]);
        end
      end
    end
  endtask

  int e0, rr;
  int want[$];
  int none[$];

  initial begin
    step(3);
    reset = 1'b1;
    step(5);

    // Clean enter press, no pulse on release
    clear_times();
    e0 = cyc;
    enter_raw = 1'b1;
    step(50);
    enter_raw = 1'b0;
    step(20);
    want.delete(); want.push_back(e0 + 7);
    chk_times("clean_enter", e_times, want);
    $display("transaction clean_enter: pulses=%0d", e_times.size());

    // Bounce rejection on right
    clear_times();
    right_raw = 1'b1; step(2);
    right_raw = 1'b0; step(2);
    right_raw = 1'b1; step(2);
    right_raw = 1'b0; step(2);
    e0 = cyc;
    right_raw = 1'b1;
    step(15);
    right_raw = 1'b0;
    step(20);
    want.delete(); want.push_back(e0 + 7);
    chk_times("bounce_right", r_times, want);
    $display("transaction bounce_right: pulses=%0d", r_times.size());

    // Auto-repeat on left
    clear_times();
    e0 = cyc;
    left_raw = 1'b1;
    step(60);
    left_raw = 1'b0;
    step(25);
    want.delete();
    want.push_back(e0 + 7);  want.push_back(e0 + 27); want.push_back(e0 + 35);
    want.push_back(e0 + 43); want.push_back(e0 + 51); want.push_back(e0 + 59);
    chk_times("repeat_left", l_times, want);
    $display("transaction repeat_left: pulses=%0d", l_times.size());

    // Right and enter together: enter wins
    clear_times();
    e0 = cyc;
    right_raw = 1'b1;
    enter_raw = 1'b1;
    step(20);
    right_raw = 1'b0;
    enter_raw = 1'b0;
    step(20);
    want.delete(); want.push_back(e0 + 7);
    chk_times("conflict_enter", e_times, want);
    chk_times("conflict_enter_right", r_times, none);
    $display("transaction conflict_enter: enter=%0d right=%0d", e_times.size(), r_times.size());

    // Both arrows together: nothing at all
    clear_times();
    left_raw = 1'b1;
    right_raw = 1'b1;
    step(60);
    left_raw = 1'b0;
    right_raw = 1'b0;
    step(20);
    chk_times("both_arrows_left", l_times, none);
    chk_times("both_arrows_right", r_times, none);
    $display("transaction both_arrows: left=%0d right=%0d", l_times.size(), r_times.size());

    // Reset in the middle of a repeat
    clear_times();
    e0 = cyc;
    left_raw = 1'b1;
    step(30);
    reset = 1'b0;
    step(3);
    rr = cyc;
    reset = 1'b1;
    step(40);
    left_raw = 1'b0;
    step(25);
    want.delete();
    want.push_back(e0 + 7);  want.push_back(e0 + 27);
    want.push_back(rr + 7);  want.push_back(rr + 27); want.push_back(rr + 35);
    want.push_back(rr + 43);
    chk_times("reset_mid_repeat", l_times, want);
    $display("transaction reset_mid_repeat: pulses=%0d", l_times.size());

    // Randomised key activity with occasional resets, checked by the scoreboard
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        reset = 1'b0;
        step($urandom_range(1, 3));
        reset = 1'b1;
      end
      if ($urandom_range(0, 29) == 0) right_raw = ~right_raw;
      if ($urandom_range(0, 29) == 0) left_raw  = ~left_raw;
      if ($urandom_range(0, 39) == 0) enter_raw = ~enter_raw;
      step(1);
    end
    $display("transaction random: done at cycle %0d", cyc);

    right_raw = 1'b0;
    left_raw  = 1'b0;
    enter_raw = 1'b0;
    step(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
